// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// (IF) and data memory (DM). It issues one access at a time, waits a fixed
// MEM_LATENCY, then returns data / write-ack to the winner with a 1-cycle pulse.
// Optional build macro STARVE_GUARD_EN: after STARVE_LIMIT consecutive lost
// arbitrations, IF is forced to win the next arbitration it takes part in.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 64,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    logic [1:0]       state;
    logic             owner_dm;   // 1: DM owns the access in flight, 0: IF
    req_t             req_q;      // latched winning request, drives the memory port
    logic [CNT_W-1:0] lat_cnt;
    logic             can_arb;
    logic             arb_any;
    logic             dm_wins;

`ifdef STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    logic [SC_W-1:0] starve_cnt;
`endif

    assign can_arb = (state == S_IDLE) || (state == S_RESP);

    // Arbitration: DM is older in program order, so it wins unless IF is starved
    always_comb begin
        arb_any = if_req | dm_req;
        dm_wins = dm_req;
`ifdef STARVE_GUARD_EN
        if (if_req && starve_cnt == SC_W'(STARVE_LIMIT))
            dm_wins = 1'b0;
`endif
    end

    // Main FSM: arbitrate, issue one strobe, count latency, respond
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            owner_dm <= 1'b0;
            req_q    <= '0;
            lat_cnt  <= '0;
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            case (state)
                S_IDLE, S_RESP: begin
                    if (arb_any) begin
                        state    <= S_ISSUE;
                        owner_dm <= dm_wins;
                        // IF reads leave the previous write data on the bus
                        if (dm_wins) req_q <= '{we: dm_we, addr: dm_addr, wdata: dm_wdata};
                        else         req_q <= '{we: 1'b0, addr: if_addr, wdata: req_q.wdata};
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    state   <= S_WAIT;
                    lat_cnt <= '0;
                end
                S_WAIT: begin
                    if (lat_cnt == CNT_W'(MEM_LATENCY - 1)) begin
                        state <= S_RESP;
                        // Only the owner's read result is captured; writes leave data alone
                        if (!req_q.we) begin
                            if (owner_dm) dm_rdata <= mem_rdata;
                            else          if_rdata <= mem_rdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef STARVE_GUARD_EN
    // Starvation counter: counts DM wins over a waiting IF, cleared by any IF win
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (can_arb && arb_any) begin
            if (!dm_wins)
                starve_cnt <= '0;
            else if (if_req && starve_cnt != SC_W'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + SC_W'(1);
        end
    end
`endif

    assign mem_en    = (state == S_ISSUE);
    assign mem_we    = mem_en & req_q.we;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;
    assign if_gnt    = mem_en & ~owner_dm;
    assign dm_gnt    = mem_en & owner_dm;
    assign if_valid  = (state == S_RESP) & ~owner_dm;
    assign dm_valid  = (state == S_RESP) & owner_dm;
    assign busy      = (state == S_ISSUE) || (state == S_WAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of request vectors with a scoreboard of
// expected grant/valid cycles and data, plus hand-written reset and
// starvation sequences. Memory is modelled with a fixed-latency responder.
module tb_mem_port_arbiter;
    localparam int AW = 32, DW = 64, LAT = 2, SLIM = 4;

    logic          clk = 1'b0, rst = 1'b1;
    logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [AW-1:0] if_addr = '0, dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0, mem_rdata = '0;
    logic          if_gnt, if_valid, dm_gnt, dm_valid, mem_en, mem_we, busy;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(SLIM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    endtask

    task automatic fail_now(input string name);
        total++;
        $display("FAIL %s cyc=%0d", name, cyc);
    endtask

    function automatic logic [63:0] dflt(input logic [31:0] a);
        return {a ^ 32'hDEAD_BEEF, a};
    endfunction

    // Memory responder: own storage, read data presented only in the cycle
    // MEM_LATENCY after the strobe, junk otherwise.
    logic [63:0] mem_store [logic [31:0]];
    int          pend_cyc = -1;
    logic [63:0] pend_data = '0;
    always @(negedge clk) begin
        if (pend_cyc == cyc) mem_rdata = pend_data;
        else                 mem_rdata = {$urandom, $urandom};
        if (mem_en === 1'b1) begin
            if (mem_we) mem_store[mem_addr] = mem_wdata;
            else begin
                pend_data = mem_store.exists(mem_addr) ? mem_store[mem_addr] : dflt(mem_addr);
                pend_cyc  = cyc + LAT;
            end
        end
    end

    // Scoreboard
    typedef struct {
        logic [31:0] addr;
        bit          we;
        logic [63:0] wd;
        logic [63:0] data;   // expected own rdata at valid
        logic [63:0] other;  // expected other port's rdata at valid
        int          gcyc;
        int          vcyc;
    } sb_t;
    sb_t         if_q[$], dm_q[$];
    sb_t         me;
    bit          sb_en = 1'b0;
    logic [63:0] gold [logic [31:0]];
    logic [63:0] if_last = '0, dm_last = '0;

    function automatic logic [63:0] gold_rd(input logic [31:0] a);
        return gold.exists(a) ? gold[a] : dflt(a);
    endfunction

    always @(negedge clk) if (sb_en) begin
        chk("mem_we_qual", 64'(mem_we & ~mem_en), 64'd0);
        if (mem_en | if_gnt | dm_gnt)
            chk("en_gnt", 64'({mem_en, if_gnt & dm_gnt}), 64'({if_gnt | dm_gnt, 1'b0}));
        if (if_gnt) begin
            if (if_q.size() == 0) fail_now("if_gnt_unexpected");
            else begin
                me = if_q[0];
                chk("if_gnt_cyc", 64'(cyc), 64'(me.gcyc));
                chk("if_mem_addr", 64'(mem_addr), 64'(me.addr));
                chk("if_mem_we", 64'(mem_we), 64'd0);
            end
        end
        if (dm_gnt) begin
            if (dm_q.size() == 0) fail_now("dm_gnt_unexpected");
            else begin
                me = dm_q[0];
                chk("dm_gnt_cyc", 64'(cyc), 64'(me.gcyc));
                chk("dm_mem_addr", 64'(mem_addr), 64'(me.addr));
                chk("dm_mem_we", 64'(mem_we), 64'(me.we));
                if (me.we) chk("dm_mem_wdata", mem_wdata, me.wd);
            end
        end
        if (if_valid | dm_valid) chk("valid_excl", 64'(if_valid & dm_valid), 64'd0);
        if (if_valid) begin
            if (if_q.size() == 0) fail_now("if_valid_unexpected");
            else begin
                me = if_q.pop_front();
                chk("if_valid_cyc", 64'(cyc), 64'(me.vcyc));
                chk("if_rdata", if_rdata, me.data);
                chk("if_dm_hold", dm_rdata, me.other);
            end
        end
        if (dm_valid) begin
            if (dm_q.size() == 0) fail_now("dm_valid_unexpected");
            else begin
                me = dm_q.pop_front();
                chk("dm_valid_cyc", 64'(cyc), 64'(me.vcyc));
                chk("dm_rdata", dm_rdata, me.data);
                chk("dm_if_hold", if_rdata, me.other);
            end
        end
    end

    typedef struct {
        bit          ifr;
        bit          dm;
        bit          we;
        logic [31:0] ia;
        logic [31:0] da;
        logic [63:0] wd;
    } vec_t;
    vec_t vecs[8];

    // Drive a vector in the current cycle and push its expected outcome.
    task automatic push_vec(input vec_t v);
        sb_t e;
        int  t;
        t = cyc;
        if (v.dm) begin
            e.addr = v.da; e.we = v.we; e.wd = v.wd;
            e.gcyc = t + 1; e.vcyc = t + 2 + LAT;
            e.other = if_last;
            if (v.we) begin gold[v.da] = v.wd; e.data = dm_last; end
            else begin e.data = gold_rd(v.da); dm_last = e.data; end
            dm_q.push_back(e);
            dm_req = 1'b1; dm_we = v.we; dm_addr = v.da; dm_wdata = v.wd;
        end
        if (v.ifr) begin
            int s;
            s = v.dm ? t + LAT + 2 : t;
            e.addr = v.ia; e.we = 1'b0; e.wd = '0;
            e.gcyc = s + 1; e.vcyc = s + 2 + LAT;
            e.data = gold_rd(v.ia); if_last = e.data;
            e.other = dm_last;
            if_q.push_back(e);
            if_req = 1'b1; if_addr = v.ia;
        end
    endtask

    // Drop each request once granted; return when everything has responded.
    task automatic run_until_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (if_gnt) if_req = 1'b0;
            if (dm_gnt) dm_req = 1'b0;
            if (!if_req && !dm_req && if_q.size() == 0 && dm_q.size() == 0) return;
        end
        fail_now("timeout");
        if_req = 1'b0; dm_req = 1'b0;
        if_q.delete(); dm_q.delete();
        repeat (LAT + 4) @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bit   got, seen;
        int   dm_n;

        vecs[0] = '{ifr: 0, dm: 1, we: 1, ia: 32'h0,         da: 32'h100,       wd: 64'hA5};
        vecs[1] = '{ifr: 0, dm: 1, we: 0, ia: 32'h0,         da: 32'h100,       wd: 64'h0};
        vecs[2] = '{ifr: 1, dm: 0, we: 0, ia: 32'h100,       da: 32'h0,         wd: 64'h0};
        vecs[3] = '{ifr: 1, dm: 1, we: 0, ia: 32'h40,        da: 32'h200,       wd: 64'h0};
        vecs[4] = '{ifr: 1, dm: 1, we: 1, ia: 32'h300,       da: 32'h40,        wd: 64'hCAFE_F00D_0BAD_BEEF};
        vecs[5] = '{ifr: 1, dm: 0, we: 0, ia: 32'h40,        da: 32'h0,         wd: 64'h0};
        vecs[6] = '{ifr: 0, dm: 1, we: 1, ia: 32'h0,         da: 32'hFFFF_FFF8, wd: 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[7] = '{ifr: 1, dm: 1, we: 0, ia: 32'hFFFF_FFF8, da: 32'hFFFF_FFF8, wd: 64'h0};

        mem_store[32'h40] = 64'h1122_3344_5566_7788;
        gold[32'h40]      = 64'h1122_3344_5566_7788;

        // Reset held 3 cycles with a fetch pending: nothing may come out
        if_req = 1'b1; if_addr = 32'h40;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("rst_ctrl", 64'({if_gnt, if_valid, dm_gnt, dm_valid, mem_en, mem_we, busy}), 64'd0);
        end
        chk("rst_if_rdata", if_rdata, 64'd0);
        chk("rst_dm_rdata", dm_rdata, 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        rst = 1'b0;
        sb_en = 1'b1;
        v = '{ifr: 1, dm: 0, we: 0, ia: 32'h40, da: 32'h0, wd: 64'h0};
        push_vec(v);
        run_until_done(30);

        // Vector table, each issued in the response cycle of the previous one
        for (int i = 0; i < 8; i++) begin
            push_vec(vecs[i]);
            run_until_done(40);
        end

        // Reset one cycle after a DM grant: access is abandoned
        sb_en = 1'b0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (dm_gnt) begin got = 1'b1; dm_req = 1'b0; break; end
        end
        chk("rw_gnt_seen", 64'(got), 64'd1);
        @(negedge clk); #1; rst = 1'b1;
        @(negedge clk); #1; rst = 1'b0;
        chk("rw_busy", 64'(busy), 64'd0);
        chk("rw_dm_rdata", dm_rdata, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk); #1;
            if (dm_valid | if_valid | mem_en) seen = 1'b1;
        end
        chk("rw_no_activity", 64'(seen), 64'd0);
        dm_last = '0; if_last = '0;
        sb_en = 1'b1;
        v = '{ifr: 0, dm: 1, we: 0, ia: 32'h0, da: 32'h40, wd: 64'h0};
        push_vec(v);
        run_until_done(30);

        // Both ports requesting continuously
        sb_en = 1'b0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h600;
        if_req = 1'b1; if_addr = 32'h608;
        dm_n = 0; seen = 1'b0;
        for (int i = 0; i < 8 * (LAT + 2); i++) begin
            @(negedge clk); #1;
            if (dm_gnt) dm_n++;
            if (if_gnt) begin seen = 1'b1; break; end
        end
        if_req = 1'b0; dm_req = 1'b0;
`ifdef STARVE_GUARD_EN
        chk("starve_dm_grants", 64'(dm_n), 64'(SLIM));
        chk("starve_if_won", 64'(seen), 64'd1);
`else
        chk("strict_if_never", 64'(seen), 64'd0);
        chk("strict_dm_grants", 64'(dm_n >= 6), 64'd1);
`endif
        repeat (LAT + 4) @(negedge clk);
        #1;
        chk("starve_idle", 64'(busy), 64'd0);
        dm_last = gold_rd(32'h600);
`ifdef STARVE_GUARD_EN
        if_last = gold_rd(32'h608);
`endif
        sb_en = 1'b1;
        v = '{ifr: 1, dm: 1, we: 0, ia: 32'h708, da: 32'h700, wd: 64'h0};
        push_vec(v);
        run_until_done(40);

        chk("queues_empty", 64'(if_q.size() + dm_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
